step_cmd_queue: RTL
===================

Name: step_cmd_queue

Overview:
- Upstream command stage for the step-pulse generator.
- Buffers 8-bit motion commands written by the host MCU in a small FIFO. Bit 7 of each command is direction; bits 6:0 are the pulse count per control period.
- Issues one command at a time to the generator through its active-low WR load strobe, and waits for the generator's busy cycle to finish before issuing the next.
- Gives the host full/empty/level status and sticky error flags.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of 2, range 2..16.
- ACK_TO, 8, clk cycles to wait for gen_busy to rise after a load strobe before flagging ack_err.
- LVL_W, 3, width of level output; must be at least log2(DEPTH)+1.

Ports:
- clk  in  1  system clock, 20 MHz, same clock as the generator.
- rst  in  1  synchronous, active-high reset.
- host_we  in  1  one-cycle write strobe, already synchronised to clk.
- host_data  in  8  command byte: [7]=dir, [6:0]=count.
- flush  in  1  synchronous; empties the FIFO.
- gen_N  out  8  command byte driven to generator N input.
- gen_WR  out  1  active-low load strobe to generator WR input.
- gen_busy  in  1  generator busy output.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- level  out  LVL_W  current entry count.
- overflow  out  1  sticky; a write was attempted while the FIFO could not accept it.
- ack_err  out  1  sticky; gen_busy did not rise within ACK_TO cycles of a load.

Behaviour:
- Reset values: gen_WR=1, gen_N=0, full=0, empty=1, level=0, overflow=0, ack_err=0, FSM=IDLE. FIFO pointers cleared.
- Reset applied mid-LOAD forces gen_WR=1 on the next edge.
- FIFO storage:
  - Registered read/write pointers and a count.
  - Status outputs are derived from the count and are registered-consistent: they update in the same edge as the push/pop.
- Push rule: the byte is accepted when host_we=1 and (count<DEPTH or a pop occurs in the same cycle).
  - Push and pop in the same cycle leave the count unchanged.
  - A write that is not accepted sets overflow. Data is dropped and FIFO contents are unchanged.
- Sticky flags:
  - overflow and ack_err clear only on rst or flush.
  - flush empties the FIFO and has priority over a simultaneous host_we.
  - flush does not abort an in-flight FSM sequence.
- FSM states:
  - IDLE:
    - gen_WR=1.
    - If FIFO is non-empty and gen_busy=0: pop the head into gen_N on the same edge, then go to LOAD.
  - LOAD:
    - gen_WR=0 for exactly 2 consecutive cycles, counted by a 1-bit counter. The generator loads when it samples WR low on two successive edges; a third low cycle would reload it, so the low period is exactly 2 cycles.
    - Then gen_WR=1 and go to WAIT_ACK.
    - gen_N is held stable from the pop until the FSM returns to IDLE.
  - WAIT_ACK:
    - Counts cycles.
    - If gen_busy=1, go to RUN.
    - If ACK_TO cycles elapse with gen_busy=0, set ack_err and go to IDLE. The command is considered consumed.
  - RUN:
    - Wait for gen_busy=0, then go to IDLE.
    - No timeout; the generator's period is 10 ms nominal.
- Latency: from a host_we into an empty FIFO with generator idle to the first gen_WR low is 2 clk edges (push edge, pop edge).
- Back-to-back commands: the minimum gap between load strobes is 2 (LOAD) + WAIT_ACK + RUN + 1 (IDLE) cycles.
- gen_busy high while in IDLE (e.g. after a reset with the generator still running): no pop until it falls.

Optional Feature:
- ZERO_SKIP_EN defined:
  - In IDLE, a head entry with host_data[6:0]==0 is popped and discarded without entering LOAD. One such entry is dropped per cycle.
  - gen_N is not updated for skipped entries.
  - Skipping is allowed even while gen_busy=1.
- ZERO_SKIP_EN undefined:
  - Zero-count entries are issued like any other, producing a 10 ms busy window with no pulses. This is the legal way to hold direction or idle the axis.

Test Plan:
- Reset, then single write 0x85 with gen_busy model idle → 2 edges later gen_N=0x85 and gen_WR=0 for exactly 2 cycles. Model raises busy; FSM reaches RUN; after busy falls, empty=1 and level=0.
- Write 5 commands 0x01..0x05 back-to-back with DEPTH=4 while the generator is busy → level=4, full=1, overflow=1. Entries 0x01..0x04 are later issued in order; 0x05 is never issued.
- Busy model never responds → ack_err=1 after ACK_TO=8 cycles in WAIT_ACK. The FSM returns to IDLE and issues the next entry. ack_err stays 1 until flush.
- With FIFO full (level=4), apply host_we on the same cycle as the IDLE pop → write accepted, level remains 4, overflow stays 0.
- Assert rst during LOAD with gen_WR=0 → next edge gen_WR=1, level=0, FSM=IDLE, and no second load observed by the model.
- ZERO_SKIP_EN: queue 0x80, 0x00, 0x03 → only 0x03 is strobed. Without the macro, all three are strobed in order.

Source files
------------

// File: rtl/step_cmd_queue.sv
// step_cmd_queue: host command FIFO plus load sequencer for the step-pulse generator.
// Build option: define ZERO_SKIP_EN to discard zero-count commands in IDLE instead of issuing them.
module step_cmd_queue #(
  parameter int DEPTH  = 4,
  parameter int ACK_TO = 8,
  parameter int LVL_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             host_we,
  input  logic [7:0]       host_data,
  input  logic             flush,
  output logic [7:0]       gen_N,
  output logic             gen_WR,
  input  logic             gen_busy,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic             overflow,
  output logic             ack_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(ACK_TO + 1);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK, RUN} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    gen_n_q, gen_n_d;
  logic          gen_wr_q, gen_wr_d;
  logic          ld_cnt_q, ld_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          overflow_q, overflow_d;
  logic          ack_err_q, ack_err_d;
  logic [7:0]    head;
  logic          issue, skip, pop, push, ack_timeout;

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    gen_n_d     = gen_n_q;
    gen_wr_d    = gen_wr_q;
    ld_cnt_d    = ld_cnt_q;
    to_cnt_d    = to_cnt_q;
    issue       = 1'b0;
    skip        = 1'b0;
    ack_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        gen_wr_d = 1'b1;
        // A flush this cycle wins over issuing the head it is about to discard.
        if (count_q != '0 && !flush) begin
`ifdef ZERO_SKIP_EN
          if (head[6:0] == 7'd0) skip = 1'b1;
          else if (!gen_busy)    issue = 1'b1;
`else
          if (!gen_busy) issue = 1'b1;
`endif
        end
        if (issue) begin
          gen_n_d  = head;
          gen_wr_d = 1'b0;
          ld_cnt_d = 1'b0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        // Exactly two low cycles: a third would make the generator reload.
        ld_cnt_d = 1'b1;
        if (ld_cnt_q) begin
          gen_wr_d = 1'b1;
          to_cnt_d = '0;
          state_d  = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (gen_busy) begin
          state_d = RUN;
        end else if (to_cnt_q == TW'(ACK_TO - 1)) begin
          ack_timeout = 1'b1;
          state_d     = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      RUN: begin
        if (!gen_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop      = issue | skip;
    push     = host_we & ~flush & ((count_q < DEPTH_C) | pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + ONE_C;
    else if (pop && !push) count_d = count_q - ONE_C;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
    overflow_d = flush ? 1'b0 : (overflow_q | (host_we & ~flush & ~push));
    ack_err_d  = flush ? 1'b0 : (ack_err_q | ack_timeout);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      gen_n_q    <= '0;
      gen_wr_q   <= 1'b1;
      ld_cnt_q   <= 1'b0;
      to_cnt_q   <= '0;
      overflow_q <= 1'b0;
      ack_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      gen_n_q    <= gen_n_d;
      gen_wr_q   <= gen_wr_d;
      ld_cnt_q   <= ld_cnt_d;
      to_cnt_q   <= to_cnt_d;
      overflow_q <= overflow_d;
      ack_err_q  <= ack_err_d;
    end
  end

  // Storage is data only; the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= host_data;
  end

  assign gen_N    = gen_n_q;
  assign gen_WR   = gen_wr_q;
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign level    = LVL_W'(count_q);
  assign overflow = overflow_q;
  assign ack_err  = ack_err_q;

endmodule
